// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
//
// Conditions the raw board switches before the memory-mapped switch input
// port. Each bit passes through a 2-flop synchronizer and then through a
// counter-based debounce FSM. A new level is accepted only after
// DEBOUNCE_CYCLES consecutive synchronized samples that differ from the
// current clean level.
//
// Ports
//   clk          in   1      system clock, all state on rising edge
//   rst          in   1      asynchronous active-high reset
//   sw_raw       in   WIDTH  raw switch pins, asynchronous to clk
//   evt_clear    in   1      one-cycle strobe: clear sticky flags in evt_mask
//   evt_mask     in   WIDTH  bits of evt_latched cleared when evt_clear=1
//   sw_clean     out  WIDTH  debounced switch levels
//   sw_changed   out  WIDTH  one-cycle pulse per bit when sw_clean[i] toggles
//   evt_latched  out  WIDTH  sticky per-bit change flags
//   any_event    out  1      OR-reduction of evt_latched
//
// Strobe semantics: evt_clear is sampled on every rising edge; there is no
// handshake. A clear and a new change event on the same bit in the same
// cycle leave the flag set, so software never loses an event it clears late.
// ---------------------------------------------------------------------------
module switch_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             evt_clear,
  input  logic [WIDTH-1:0] evt_mask,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed,
  output logic [WIDTH-1:0] evt_latched,
  output logic             any_event
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Last count value before acceptance; reaching it with a still-differing
  // sample means DEBOUNCE_CYCLES stable samples have been seen.
  localparam logic [CW-1:0] TERM_CNT = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  // Synchronizer
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce
  logic [WIDTH-1:0] clean_q;
  logic [WIDTH-1:0] clean_d;
  logic [WIDTH-1:0] changed_q;
  logic [WIDTH-1:0] changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      clean_d[i]   = clean_q[i];
      changed_d[i] = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sync2_q[i] != clean_q[i]) begin
            state_d = ST_COUNT;
            cnt_d   = ONE_CNT;
          end else begin
            cnt_d   = '0;
          end
        end
        ST_COUNT: begin
          if (sync2_q[i] == clean_q[i]) begin
            // Bounce back to the accepted level: discard progress.
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == TERM_CNT) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            clean_d[i]   = ~clean_q[i];
            changed_d[i] = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE_CNT;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs and sticky flags
  logic [WIDTH-1:0] evt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clean_q   <= '0;
      changed_q <= '0;
      evt_q     <= '0;
    end else begin
      clean_q   <= clean_d;
      changed_q <= changed_d;
      // Set term is ORed last so a same-cycle set beats the clear.
      evt_q     <= (evt_q & ~({WIDTH{evt_clear}} & evt_mask)) | changed_d;
    end
  end

  assign sw_clean    = clean_q;
  assign sw_changed  = changed_q;
  assign evt_latched = evt_q;
  assign any_event   = |evt_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// ---------------------------------------------------------------------------
// tb_switch_debouncer
//
// Directed bench for switch_debouncer with WIDTH=8, DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each tick() observes the state produced by that edge.
// With 4 debounce cycles a clean step reaches sw_clean on the 6th rising
// edge counted from the first edge that samples the new raw level.
// ---------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic         evt_clear;
  logic [W-1:0] evt_mask;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_changed;
  logic [W-1:0] evt_latched;
  logic         any_event;

  int checks;
  int errors;

  switch_debouncer #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .evt_clear  (evt_clear),
    .evt_mask   (evt_mask),
    .sw_clean   (sw_clean),
    .sw_changed (sw_changed),
    .evt_latched(evt_latched),
    .any_event  (any_event)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 1: reset and idle
  task automatic test_reset();
    rst       = 1'b1;
    sw_raw    = 8'h00;
    evt_clear = 1'b0;
    evt_mask  = 8'h00;
    repeat (3) tick();
    checks++;
    if ({sw_clean, sw_changed, evt_latched, any_event} !== 25'd0) begin
      errors++;
      $display("FAIL reset_hold: clean=%h chg=%h evt=%h any=%b, want all 0",
               sw_clean, sw_changed, evt_latched, any_event);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if ({sw_clean, sw_changed, evt_latched, any_event} !== 25'd0) begin
        errors++;
        $display("FAIL idle_zero cyc%0d: clean=%h chg=%h evt=%h any=%b, want all 0",
                 k, sw_clean, sw_changed, evt_latched, any_event);
      end
    end
  endtask

  // 2: single bit step latency and event
  task automatic test_single_bit();
    sw_raw = 8'h01;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 6) begin
        checks++;
        if (sw_clean !== 8'h00 || sw_changed !== 8'h00) begin
          errors++;
          $display("FAIL step_early edge%0d: clean=%h chg=%h, want 00 00",
                   k, sw_clean, sw_changed);
        end
      end
    end
    checks++;
    if (sw_clean !== 8'h01 || sw_changed !== 8'h01) begin
      errors++;
      $display("FAIL step_edge6: clean=%h chg=%h, want 01 01", sw_clean, sw_changed);
    end
    tick();
    checks++;
    if (sw_clean !== 8'h01 || sw_changed !== 8'h00 || evt_latched !== 8'h01
        || any_event !== 1'b1) begin
      errors++;
      $display("FAIL step_after: clean=%h chg=%h evt=%h any=%b, want 01 00 01 1",
               sw_clean, sw_changed, evt_latched, any_event);
    end
  endtask

  // 3: bounce on bit 3 resets the count
  task automatic test_bounce();
    int rise_at;
    int pulses;
    rise_at = -1;
    pulses  = 0;
    sw_raw = 8'h09;
    repeat (3) begin
      tick();
      if (sw_changed[3]) pulses++;
    end
    sw_raw = 8'h01;
    tick();
    if (sw_changed[3]) pulses++;
    sw_raw = 8'h09;
    checks++;
    if (sw_clean[3] !== 1'b0) begin
      errors++;
      $display("FAIL bounce_early: clean[3]=%b, want 0", sw_clean[3]);
    end
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (sw_changed[3]) pulses++;
      if (sw_clean[3] === 1'b1 && rise_at < 0) rise_at = j;
    end
    checks++;
    if (rise_at != 6) begin
      errors++;
      $display("FAIL bounce_rise_edge: got %0d, want 6", rise_at);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL bounce_pulses: got %0d, want 1", pulses);
    end
    checks++;
    if (sw_clean !== 8'h09) begin
      errors++;
      $display("FAIL bounce_clean: got %h, want 09", sw_clean);
    end
  endtask

  // 4: several bits toggle together
  task automatic test_multi_bit();
    int rise_at;
    int pulses;
    logic [W-1:0] chg_at_rise;
    sw_raw = 8'h00;
    repeat (10) tick();
    evt_clear = 1'b1;
    evt_mask  = 8'hFF;
    tick();
    evt_clear = 1'b0;
    evt_mask  = 8'h00;
    checks++;
    if (sw_clean !== 8'h00 || evt_latched !== 8'h00 || any_event !== 1'b0) begin
      errors++;
      $display("FAIL multi_prep: clean=%h evt=%h any=%b, want 00 00 0",
               sw_clean, evt_latched, any_event);
    end
    rise_at     = -1;
    pulses      = 0;
    chg_at_rise = 8'h00;
    sw_raw = 8'hA5;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (sw_changed !== 8'h00) pulses++;
      if (sw_clean === 8'hA5 && rise_at < 0) begin
        rise_at     = j;
        chg_at_rise = sw_changed;
      end
    end
    checks++;
    if (rise_at != 6) begin
      errors++;
      $display("FAIL multi_rise_edge: got %0d, want 6", rise_at);
    end
    checks++;
    if (chg_at_rise !== 8'hA5 || pulses != 1) begin
      errors++;
      $display("FAIL multi_pulse: chg=%h pulses=%0d, want A5 1", chg_at_rise, pulses);
    end
    checks++;
    if (evt_latched !== 8'hA5 || any_event !== 1'b1) begin
      errors++;
      $display("FAIL multi_evt: evt=%h any=%b, want A5 1", evt_latched, any_event);
    end
  endtask

  // 5: sticky clear, zero mask, set-beats-clear
  task automatic test_clear();
    evt_clear = 1'b1;
    evt_mask  = 8'h00;
    tick();
    checks++;
    if (evt_latched !== 8'hA5) begin
      errors++;
      $display("FAIL clear_mask0: got %h, want A5", evt_latched);
    end
    evt_mask = 8'h05;
    tick();
    evt_clear = 1'b0;
    evt_mask  = 8'h00;
    checks++;
    if (evt_latched !== 8'hA0) begin
      errors++;
      $display("FAIL clear_mask05: got %h, want A0", evt_latched);
    end
    sw_raw = 8'h85;
    repeat (5) tick();
    evt_clear = 1'b1;
    evt_mask  = 8'h20;
    tick();
    evt_clear = 1'b0;
    evt_mask  = 8'h00;
    checks++;
    if (sw_clean !== 8'h85 || sw_changed !== 8'h20) begin
      errors++;
      $display("FAIL clear_toggle: clean=%h chg=%h, want 85 20", sw_clean, sw_changed);
    end
    checks++;
    if (evt_latched !== 8'hA0) begin
      errors++;
      $display("FAIL set_beats_clear: got %h, want A0", evt_latched);
    end
  endtask

  // 6: reset mid-count, then re-debounce from zero
  task automatic test_reset_mid_count();
    sw_raw = 8'hFF;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({sw_clean, sw_changed, evt_latched, any_event} !== 25'd0) begin
      errors++;
      $display("FAIL async_reset: clean=%h chg=%h evt=%h any=%b, want all 0",
               sw_clean, sw_changed, evt_latched, any_event);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 6) begin
        checks++;
        if (sw_clean !== 8'h00) begin
          errors++;
          $display("FAIL rst_redebounce edge%0d: clean=%h, want 00", k, sw_clean);
        end
      end
    end
    checks++;
    if (sw_clean !== 8'hFF || sw_changed !== 8'hFF || evt_latched !== 8'hFF) begin
      errors++;
      $display("FAIL rst_release_edge6: clean=%h chg=%h evt=%h, want FF FF FF",
               sw_clean, sw_changed, evt_latched);
    end
    tick();
    checks++;
    if (sw_changed !== 8'h00 || sw_clean !== 8'hFF) begin
      errors++;
      $display("FAIL rst_release_after: clean=%h chg=%h, want FF 00",
               sw_clean, sw_changed);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_bit();
    test_bounce();
    test_multi_bit();
    test_clear();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
